peak_trough_tracker: RTL and testbench

Parametrised successor to the fixed-width peak/trough counter. It sits downstream of the FIR filter on the sample-valid stream. It detects local extrema with programmable hysteresis and a refractory gap, and counts peaks and troughs in saturating counters. It also reports the peak-to-peak interval in samples, which firmware uses for rate estimation.

---
 rtl/peak_trough_tracker.sv | 184 ++++++++++++++++++
 tb/tb_peak_trough_tracker.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/peak_trough_tracker.sv
// Local-extremum detector with hysteresis and refractory gap on a sample-valid stream.
// Counts accepted peaks/troughs (saturating) and reports the peak-to-peak interval in valid samples.
module peak_trough_tracker #(
    parameter int DATA_W = 10,
    parameter int CNT_W  = 16,
    parameter int GAP_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] hyst,
    input  logic [GAP_W-1:0]  min_gap,
    output logic              peak_pulse,
    output logic              trough_pulse,
    output logic [DATA_W-1:0] peak_value,
    output logic [DATA_W-1:0] trough_value,
    output logic [CNT_W-1:0]  num_peaks,
    output logic [CNT_W-1:0]  num_troughs,
    output logic [GAP_W-1:0]  peak_interval,
    output logic              interval_valid
);

    typedef enum logic [1:0] {INIT, RISING, FALLING} state_t;

    state_t            state, state_n;
    logic              seen, seen_n;
    logic              have_pk, have_pk_n;
    logic [DATA_W-1:0] mx, mx_n, mn, mn_n;
    logic [GAP_W-1:0]  since_pk, since_pk_n, since_tr, since_tr_n;

    logic              peak_pulse_n, trough_pulse_n, interval_valid_n;
    logic [DATA_W-1:0] peak_value_n, trough_value_n;
    logic [CNT_W-1:0]  num_peaks_n, num_troughs_n;
    logic [GAP_W-1:0]  peak_interval_n;

    logic              pk_cand, tr_cand;
    logic [DATA_W-1:0] h;
    logic [DATA_W:0]   s_x, h_x, mx_x, mn_x;

    // One extra bit so sample+h and min+h never wrap.
    assign h    = (hyst == '0) ? DATA_W'(1) : hyst;
    assign s_x  = {1'b0, sample};
    assign h_x  = {1'b0, h};
    assign mx_x = {1'b0, mx};
    assign mn_x = {1'b0, mn};

    always_comb begin
        state_n          = state;
        seen_n           = seen;
        have_pk_n        = have_pk;
        mx_n             = mx;
        mn_n             = mn;
        since_pk_n       = since_pk;
        since_tr_n       = since_tr;
        peak_pulse_n     = 1'b0;
        trough_pulse_n   = 1'b0;
        interval_valid_n = 1'b0;
        peak_value_n     = peak_value;
        trough_value_n   = trough_value;
        num_peaks_n      = num_peaks;
        num_troughs_n    = num_troughs;
        peak_interval_n  = peak_interval;
        pk_cand          = 1'b0;
        tr_cand          = 1'b0;

        if (sample_valid) begin
            since_pk_n = (&since_pk) ? since_pk : since_pk + GAP_W'(1);
            since_tr_n = (&since_tr) ? since_tr : since_tr + GAP_W'(1);

            case (state)
                INIT: begin
                    if (!seen) begin
                        mx_n   = sample;
                        mn_n   = sample;
                        seen_n = 1'b1;
                    end else begin
                        if (sample > mx) mx_n = sample;
                        if (sample < mn) mn_n = sample;
                        if (s_x >= mn_x + h_x) begin
                            state_n = RISING;
                            mx_n    = sample;
                        end else if (s_x + h_x <= mx_x) begin
                            state_n = FALLING;
                            mn_n    = sample;
                        end
                    end
                end
                RISING: begin
                    if (s_x + h_x <= mx_x) begin
                        pk_cand = 1'b1;
                        state_n = FALLING;
                        mn_n    = sample;
                    end else if (sample > mx) begin
                        mx_n = sample;
                    end
                end
                FALLING: begin
                    if (s_x >= mn_x + h_x) begin
                        tr_cand = 1'b1;
                        state_n = RISING;
                        mx_n    = sample;
                    end else if (sample < mn) begin
                        mn_n = sample;
                    end
                end
                default: state_n = INIT;
            endcase

            // Refractory test uses the distance before this sample's increment.
            if (pk_cand && since_pk >= min_gap) begin
                peak_pulse_n = 1'b1;
                peak_value_n = mx;
                num_peaks_n  = (&num_peaks) ? num_peaks : num_peaks + CNT_W'(1);
                since_pk_n   = '0;
                if (have_pk) begin
                    peak_interval_n  = since_pk;
                    interval_valid_n = 1'b1;
                end
                have_pk_n = 1'b1;
            end
            if (tr_cand && since_tr >= min_gap) begin
                trough_pulse_n = 1'b1;
                trough_value_n = mn;
                num_troughs_n  = (&num_troughs) ? num_troughs : num_troughs + CNT_W'(1);
                since_tr_n     = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= INIT;
            seen           <= 1'b0;
            have_pk        <= 1'b0;
            mx             <= '0;
            mn             <= '0;
            since_pk       <= '1;
            since_tr       <= '1;
            peak_pulse     <= 1'b0;
            trough_pulse   <= 1'b0;
            interval_valid <= 1'b0;
            peak_value     <= '0;
            trough_value   <= '0;
            num_peaks      <= '0;
            num_troughs    <= '0;
            peak_interval  <= '0;
        end else if (clear) begin
            state          <= INIT;
            seen           <= 1'b0;
            have_pk        <= 1'b0;
            mx             <= '0;
            mn             <= '0;
            since_pk       <= '1;
            since_tr       <= '1;
            peak_pulse     <= 1'b0;
            trough_pulse   <= 1'b0;
            interval_valid <= 1'b0;
            peak_value     <= '0;
            trough_value   <= '0;
            num_peaks      <= '0;
            num_troughs    <= '0;
            peak_interval  <= '0;
        end else begin
            state          <= state_n;
            seen           <= seen_n;
            have_pk        <= have_pk_n;
            mx             <= mx_n;
            mn             <= mn_n;
            since_pk       <= since_pk_n;
            since_tr       <= since_tr_n;
            peak_pulse     <= peak_pulse_n;
            trough_pulse   <= trough_pulse_n;
            interval_valid <= interval_valid_n;
            peak_value     <= peak_value_n;
            trough_value   <= trough_value_n;
            num_peaks      <= num_peaks_n;
            num_troughs    <= num_troughs_n;
            peak_interval  <= peak_interval_n;
        end
    end

endmodule

// File: tb/tb_peak_trough_tracker.sv
// Directed bench for peak_trough_tracker: default-width instance plus a narrow
// (CNT_W=2, GAP_W=4) instance on the same stream for saturation cases.
module tb_peak_trough_tracker;

    logic        clk, reset, clear, sample_valid;
    logic [9:0]  sample, hyst;
    logic [15:0] min_gap;

    logic        peak_pulse, trough_pulse, interval_valid;
    logic [9:0]  peak_value, trough_value;
    logic [15:0] num_peaks, num_troughs, peak_interval;

    logic        peak_pulse2, trough_pulse2, interval_valid2;
    logic [9:0]  peak_value2, trough_value2;
    logic [1:0]  num_peaks2, num_troughs2;
    logic [3:0]  peak_interval2;

    int checks = 0;
    int failures = 0;

    peak_trough_tracker dut (
        .clk(clk), .reset(reset), .clear(clear), .sample_valid(sample_valid),
        .sample(sample), .hyst(hyst), .min_gap(min_gap),
        .peak_pulse(peak_pulse), .trough_pulse(trough_pulse),
        .peak_value(peak_value), .trough_value(trough_value),
        .num_peaks(num_peaks), .num_troughs(num_troughs),
        .peak_interval(peak_interval), .interval_valid(interval_valid)
    );

    peak_trough_tracker #(.DATA_W(10), .CNT_W(2), .GAP_W(4)) dut2 (
        .clk(clk), .reset(reset), .clear(clear), .sample_valid(sample_valid),
        .sample(sample), .hyst(hyst), .min_gap(min_gap[3:0]),
        .peak_pulse(peak_pulse2), .trough_pulse(trough_pulse2),
        .peak_value(peak_value2), .trough_value(trough_value2),
        .num_peaks(num_peaks2), .num_troughs(num_troughs2),
        .peak_interval(peak_interval2), .interval_valid(interval_valid2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [9:0] s);
        @(negedge clk);
        sample = s;
        sample_valid = 1'b1;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sample_valid = 1'b0;
            @(posedge clk);
            #1;
            checks++;
            if ({peak_pulse, trough_pulse, interval_valid} !== 3'b000) begin
                failures++;
                $display("FAIL idle_no_pulse got %b required 000", {peak_pulse, trough_pulse, interval_valid});
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({peak_pulse, trough_pulse, interval_valid, peak_value, trough_value, num_peaks, num_troughs, peak_interval} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got pv=%0d tv=%0d np=%0d nt=%0d pi=%0d required all 0",
                     peak_value, trough_value, num_peaks, num_troughs, peak_interval);
        end
        checks++;
        if ({peak_pulse2, trough_pulse2, interval_valid2, peak_value2, trough_value2, num_peaks2, num_troughs2, peak_interval2} !== '0) begin
            failures++;
            $display("FAIL reset_outputs2 got np=%0d nt=%0d pi=%0d required all 0", num_peaks2, num_troughs2, peak_interval2);
        end
    endtask

    // 10,12,20,30,25,24,28,40,35 with hyst=4, min_gap=0; gaps idle cycles between samples.
    task automatic run_seq(input int gaps, input string tag);
        logic [9:0] pre [4] = '{10, 12, 20, 30};
        do_reset();
        hyst = 10'd4;
        min_gap = 16'd0;
        foreach (pre[i]) begin
            send(pre[i]);
            checks++;
            if ({peak_pulse, trough_pulse} !== 2'b00) begin
                failures++;
                $display("FAIL %s_pre%0d got pulses %b required 00", tag, i, {peak_pulse, trough_pulse});
            end
            idle(gaps);
        end
        send(10'd25);
        checks++;
        if ({peak_pulse, peak_value, num_peaks, interval_valid} !== {1'b1, 10'd30, 16'd1, 1'b0}) begin
            failures++;
            $display("FAIL %s_peak1 got pp=%b pv=%0d np=%0d iv=%b required 1/30/1/0", tag, peak_pulse, peak_value, num_peaks, interval_valid);
        end
        idle(gaps);
        send(10'd24);
        checks++;
        if ({peak_pulse, trough_pulse} !== 2'b00) begin
            failures++;
            $display("FAIL %s_s24 got pulses %b required 00", tag, {peak_pulse, trough_pulse});
        end
        idle(gaps);
        send(10'd28);
        checks++;
        if ({trough_pulse, trough_value, num_troughs, peak_pulse} !== {1'b1, 10'd24, 16'd1, 1'b0}) begin
            failures++;
            $display("FAIL %s_trough1 got tp=%b tv=%0d nt=%0d pp=%b required 1/24/1/0", tag, trough_pulse, trough_value, num_troughs, peak_pulse);
        end
        idle(gaps);
        send(10'd40);
        checks++;
        if ({peak_pulse, trough_pulse} !== 2'b00) begin
            failures++;
            $display("FAIL %s_s40 got pulses %b required 00", tag, {peak_pulse, trough_pulse});
        end
        idle(gaps);
        send(10'd35);
        checks++;
        if ({peak_pulse, peak_value, num_peaks, interval_valid, peak_interval} !== {1'b1, 10'd40, 16'd2, 1'b1, 16'd3}) begin
            failures++;
            $display("FAIL %s_peak2 got pp=%b pv=%0d np=%0d iv=%b pi=%0d required 1/40/2/1/3",
                     tag, peak_pulse, peak_value, num_peaks, interval_valid, peak_interval);
        end
        idle(gaps > 0 ? gaps : 1);
    endtask

    task automatic test_basic();
        run_seq(0, "basic");
    endtask

    task automatic test_gated();
        run_seq(3, "gated");
    endtask

    task automatic test_refractory();
        logic [9:0] tri_s [14] = '{10, 12, 14, 12, 10, 12, 14, 12, 10, 12, 14, 12, 10, 12};
        logic exp_p, exp_t;
        do_reset();
        hyst = 10'd2;
        min_gap = 16'd5;
        foreach (tri_s[i]) begin
            send(tri_s[i]);
            exp_p = (i == 3) || (i == 11);
            exp_t = (i == 5) || (i == 13);
            checks++;
            if ({peak_pulse, trough_pulse} !== {exp_p, exp_t}) begin
                failures++;
                $display("FAIL refr_sample%0d got pulses %b required %b", i, {peak_pulse, trough_pulse}, {exp_p, exp_t});
            end
        end
        checks++;
        if ({num_peaks, num_troughs, peak_interval, peak_value, trough_value} !== {16'd2, 16'd2, 16'd7, 10'd14, 10'd10}) begin
            failures++;
            $display("FAIL refr_totals got np=%0d nt=%0d pi=%0d pv=%0d tv=%0d required 2/2/7/14/10",
                     num_peaks, num_troughs, peak_interval, peak_value, trough_value);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        hyst = 10'd2;
        min_gap = 16'd0;
        send(10'd10);
        send(10'd14);
        for (int i = 0; i < 4; i++) begin
            send(10'd10);
            send(10'd14);
        end
        send(10'd10);
        checks++;
        if ({num_peaks, num_peaks2, peak_pulse2} !== {16'd5, 2'd3, 1'b1}) begin
            failures++;
            $display("FAIL sat_count got np=%0d np2=%0d pp2=%b required 5/3/1", num_peaks, num_peaks2, peak_pulse2);
        end
        for (int i = 0; i < 20; i++) send(10'd10);
        send(10'd14);
        send(10'd10);
        checks++;
        if ({peak_pulse, interval_valid, peak_interval} !== {1'b1, 1'b1, 16'd21}) begin
            failures++;
            $display("FAIL sat_interval_wide got pp=%b iv=%b pi=%0d required 1/1/21", peak_pulse, interval_valid, peak_interval);
        end
        checks++;
        if ({peak_pulse2, interval_valid2, peak_interval2, num_peaks2} !== {1'b1, 1'b1, 4'd15, 2'd3}) begin
            failures++;
            $display("FAIL sat_interval_narrow got pp2=%b iv2=%b pi2=%0d np2=%0d required 1/1/15/3",
                     peak_pulse2, interval_valid2, peak_interval2, num_peaks2);
        end
    endtask

    task automatic test_async_reset();
        logic [9:0] s [8] = '{10, 12, 20, 30, 25, 24, 28, 40};
        do_reset();
        hyst = 10'd4;
        min_gap = 16'd0;
        foreach (s[i]) send(s[i]);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({peak_pulse, trough_pulse, interval_valid, peak_value, trough_value, num_peaks, num_troughs, peak_interval} !== '0) begin
            failures++;
            $display("FAIL async_reset got pv=%0d tv=%0d np=%0d nt=%0d required all 0", peak_value, trough_value, num_peaks, num_troughs);
        end
        @(negedge clk);
        reset = 1'b0;
        send(10'd10);
        send(10'd12);
        send(10'd20);
        send(10'd30);
        send(10'd25);
        checks++;
        if ({peak_pulse, peak_value, num_peaks, interval_valid} !== {1'b1, 10'd30, 16'd1, 1'b0}) begin
            failures++;
            $display("FAIL post_reset_peak got pp=%b pv=%0d np=%0d iv=%b required 1/30/1/0", peak_pulse, peak_value, num_peaks, interval_valid);
        end
    endtask

    task automatic test_clear();
        @(negedge clk);
        clear = 1'b1;
        sample_valid = 1'b1;
        sample = 10'd100;
        @(posedge clk);
        #1;
        clear = 1'b0;
        sample_valid = 1'b0;
        checks++;
        if ({peak_pulse, trough_pulse, num_peaks, num_troughs, peak_value} !== '0) begin
            failures++;
            $display("FAIL clear_outputs got np=%0d nt=%0d pv=%0d required 0", num_peaks, num_troughs, peak_value);
        end
        send(10'd50);
        send(10'd60);
        checks++;
        if ({peak_pulse, trough_pulse} !== 2'b00) begin
            failures++;
            $display("FAIL clear_ignored_sample got pulses %b required 00", {peak_pulse, trough_pulse});
        end
        send(10'd55);
        checks++;
        if ({peak_pulse, peak_value, num_peaks} !== {1'b1, 10'd60, 16'd1}) begin
            failures++;
            $display("FAIL clear_then_peak got pp=%b pv=%0d np=%0d required 1/60/1", peak_pulse, peak_value, num_peaks);
        end
    endtask

    task automatic test_hyst_zero();
        logic [9:0] s [4] = '{5, 6, 6, 8};
        do_reset();
        hyst = 10'd0;
        min_gap = 16'd0;
        foreach (s[i]) begin
            send(s[i]);
            checks++;
            if (peak_pulse !== 1'b0) begin
                failures++;
                $display("FAIL hyst0_s%0d got pp=%b required 0", i, peak_pulse);
            end
        end
        send(10'd7);
        checks++;
        if ({peak_pulse, peak_value} !== {1'b1, 10'd8}) begin
            failures++;
            $display("FAIL hyst0_peak got pp=%b pv=%0d required 1/8", peak_pulse, peak_value);
        end
    endtask

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        sample_valid = 1'b0;
        sample = '0;
        hyst = 10'd4;
        min_gap = '0;
        test_reset();
        @(negedge clk);
        reset = 1'b0;
        test_basic();
        test_gated();
        test_refractory();
        test_saturate();
        test_async_reset();
        test_clear();
        test_hyst_zero();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
